conv_arbiter: RTL

CONV_ARBITER -- requirements
Module: conv_arbiter

---
 rtl/conv_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/conv_arbiter.sv
// Two-requester round-robin front end for a convolution engine: grants one job,
// launches it with a one-cycle start pulse and returns ack (with err on timeout).
module conv_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CFG_W          = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req,
  input  logic [3*CFG_W-1:0] cfg0,
  input  logic [3*CFG_W-1:0] cfg1,
  output logic [1:0]         gnt,
  output logic [1:0]         ack,
  output logic               err,
  output logic               busy,
  output logic               conv_start,
  output logic [CFG_W-1:0]   conv_x,
  output logic [CFG_W-1:0]   conv_y,
  output logic [CFG_W-1:0]   conv_z,
  input  logic               conv_done
);

  typedef enum logic [1:0] {IDLE, START, WAIT, FIN} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t             state_q;
  logic [1:0]         gnt_q, ack_q;
  logic               err_q, busy_q, start_q;
  logic [CFG_W-1:0]   x_q, y_q, z_q;
  logic [15:0]        cnt_q;
  logic               last_q, own_q;
  logic               win;
  logic [3*CFG_W-1:0] cfg_sel;
  logic               timeout_hit;

  // Round-robin: a lone request wins; on contention the one not served last wins.
  always_comb begin
    win = 1'b0;
    if (req == 2'b10)      win = 1'b1;
    else if (req == 2'b11) win = ~last_q;
  end

  assign cfg_sel     = win ? cfg1 : cfg0;
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      ack_q   <= 2'b00;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= 16'd0;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 2'b00;
          err_q <= 1'b0;
          if (|req) begin
            own_q   <= win;
            gnt_q   <= win ? 2'b10 : 2'b01;
            x_q     <= cfg_sel[3*CFG_W-1:2*CFG_W];
            y_q     <= cfg_sel[2*CFG_W-1:CFG_W];
            z_q     <= cfg_sel[CFG_W-1:0];
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          start_q <= 1'b0;
          cnt_q   <= 16'd0;
          state_q <= WAIT;
        end
        WAIT: begin
          // A done arriving in the final timeout cycle still counts as success.
          if (conv_done || timeout_hit) begin
            gnt_q   <= 2'b00;
            ack_q   <= own_q ? 2'b10 : 2'b01;
            err_q   <= ~conv_done;
            state_q <= FIN;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        FIN: begin
          ack_q   <= 2'b00;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          last_q  <= own_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign ack        = ack_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign conv_start = start_q;
  assign conv_x     = x_q;
  assign conv_y     = y_q;
  assign conv_z     = z_q;

endmodule
